// File: rtl/debug_dump_tx.sv
//----------------------------------------------------------------------------
// debug_dump_tx : snapshots PC and register 0, sends them as a UART 8N1 frame.
// Optional sync header 0xA5 enabled by defining DEBUG_DUMP_HEADER_EN.
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module debug_dump_tx #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] inPc,
  input  logic [31:0] inRegistro0,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
`ifdef DEBUG_DUMP_HEADER_EN
  localparam logic [3:0]  LAST_BYTE = 4'd8;
  localparam logic [7:0]  SYNC_BYTE = 8'hA5;
`else
  localparam logic [3:0]  LAST_BYTE = 4'd7;
`endif

  state_t      state;
  logic [15:0] baud;
  logic [2:0]  bit_idx;
  logic [3:0]  byte_idx;
  logic [63:0] snapshot;

  logic [2:0]  data_idx;
  logic [63:0] shifted;
  logic [7:0]  cur_byte;
  logic        bit_end;

  // Byte being sent: snapshot bytes go out most-significant first.
  always_comb begin
`ifdef DEBUG_DUMP_HEADER_EN
    data_idx = byte_idx[2:0] - 3'd1;
`else
    data_idx = byte_idx[2:0];
`endif
    shifted  = snapshot << {data_idx, 3'b000};
    cur_byte = shifted[63:56];
`ifdef DEBUG_DUMP_HEADER_EN
    if (byte_idx == 4'd0) begin
      cur_byte = SYNC_BYTE;
    end
`endif
    bit_end = (baud == BAUD_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud     <= 16'd0;
      bit_idx  <= 3'd0;
      byte_idx <= 4'd0;
      snapshot <= 64'd0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          baud <= 16'd0;
          tx   <= 1'b1;
          if (start) begin
            snapshot <= {inPc, inRegistro0};
            byte_idx <= 4'd0;
            bit_idx  <= 3'd0;
            tx       <= 1'b0;
            busy     <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          if (bit_end) begin
            baud    <= 16'd0;
            bit_idx <= 3'd0;
            tx      <= cur_byte[0];
            state   <= DATA;
          end else begin
            baud <= baud + 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud <= 16'd0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= cur_byte[bit_idx + 3'd1];
            end
          end else begin
            baud <= baud + 16'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud <= 16'd0;
            if (byte_idx < LAST_BYTE) begin
              byte_idx <= byte_idx + 4'd1;
              tx       <= 1'b0;
              state    <= START;
            end else begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end
          end else begin
            baud <= baud + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_debug_dump_tx.sv
//----------------------------------------------------------------------------
// tb_debug_dump_tx : directed bench with a line-level UART decoder and byte
// scoreboard for debug_dump_tx (honours DEBUG_DUMP_HEADER_EN if defined).
//----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_debug_dump_tx;

  localparam int CPB = 4;
`ifdef DEBUG_DUMP_HEADER_EN
  localparam int NBYTES = 9;
`else
  localparam int NBYTES = 8;
`endif
  localparam int FRAME_CYC = NBYTES * 10 * CPB;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] pc = 32'd0;
  logic [31:0] r0 = 32'd0;
  logic        tx, busy, done;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  debug_dump_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .inPc        (pc),
    .inRegistro0 (r0),
    .tx          (tx),
    .busy        (busy),
    .done        (done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [31:0] p, input logic [31:0] r);
`ifdef DEBUG_DUMP_HEADER_EN
    exp_q.push_back(8'hA5);
`endif
    for (int i = 3; i >= 0; i--) exp_q.push_back(p[8*i +: 8]);
    for (int i = 3; i >= 0; i--) exp_q.push_back(r[8*i +: 8]);
  endtask

  // Line decoder: samples tx mid-bit on falling edges, pops the scoreboard.
  bit         dec_act = 1'b0;
  int         dec_cnt = 0;
  logic [7:0] dec_sh = 8'h00;
  always @(negedge clk) begin
    if (!rst_n) begin
      dec_act = 1'b0;
      dec_cnt = 0;
    end else if (!dec_act) begin
      if (tx === 1'b0) begin
        dec_act = 1'b1;
        dec_cnt = 0;
      end
    end else begin
      dec_cnt++;
      if (dec_cnt >= CPB/2 && ((dec_cnt - CPB/2) % CPB) == 0) begin
        int bitnum;
        bitnum = (dec_cnt - CPB/2) / CPB;
        if (bitnum == 0) begin
          check("rx_start_bit", tx, 1'b0);
        end else if (bitnum <= 8) begin
          dec_sh[bitnum-1] = tx;
        end else begin
          check("rx_stop_bit", tx, 1'b1);
          check("rx_byte_expected", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) check("rx_byte", dec_sh, exp_q.pop_front());
          dec_act = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) if (rst_n && done === 1'b1) done_cnt++;

  task automatic run_frame(input logic [31:0] p, input logic [31:0] r,
                           input bit change_after, input int ignore_at, input string tag);
    int d0;
    int n;
    d0 = done_cnt;
    pc = p;
    r0 = r;
    push_frame(p, r);
    start = 1'b1;
    tick();
    start = 1'b0;
    if (change_after) begin
      pc = $urandom;
      r0 = $urandom;
    end
    check({tag, "_latency"}, {busy, tx}, 2'b10);
    n = 1;
    while (busy === 1'b1 && n <= FRAME_CYC + 20) begin
      start = (n == ignore_at);
      tick();
      if (busy === 1'b1) n++;
    end
    start = 1'b0;
    check({tag, "_busy_len"}, n, FRAME_CYC);
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_tx_end"}, tx, 1'b1);
    tick();
    check({tag, "_done_once"}, done, 1'b0);
    repeat (CPB * 3) tick();
    check({tag, "_idle"}, busy, 1'b0);
    check({tag, "_done_cnt"}, done_cnt - d0, 1);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    int d0;
    int n;
    bit idle_ok;

    // Reset
    repeat (3) tick();
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    tick();
    check("post_rst_tx", tx, 1'b1);
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_done", done, 1'b0);
    idle_ok = 1'b1;
    repeat (50) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) idle_ok = 1'b0;
    end
    check("idle_50", idle_ok, 1'b1);

    // Single dump, snapshot hold, ignored start
    run_frame(32'h0000_0010, 32'h05EB_D7AF, 1'b0, -1, "single");
    run_frame(32'hDEAD_BEEF, 32'h8001_7E01, 1'b1, -1, "snap_hold");
    run_frame(32'h1234_5678, 32'hFFFF_0000, 1'b0, 100, "ign_start");

    // Reset mid-frame
    d0 = done_cnt;
    pc = 32'hCAFE_F00D;
    r0 = 32'h0BAD_C0DE;
    push_frame(pc, r0);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (149) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_tx", tx, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    repeat (3) tick();
    check("midrst_no_done", done_cnt - d0, 0);
    exp_q.delete();
    rst_n = 1'b1;
    tick();
    run_frame(32'h0000_0010, 32'h05EB_D7AF, 1'b0, -1, "after_rst");

    // Back-to-back with start held high
    d0 = done_cnt;
    pc = 32'hA1B2_C3D4;
    r0 = 32'h0102_0304;
    push_frame(pc, r0);
    push_frame(pc, r0);
    start = 1'b1;
    n = 0;
    tick();
    while (done !== 1'b1 && n < 2 * FRAME_CYC) begin
      tick();
      n++;
    end
    check("b2b_done1", done, 1'b1);
    tick();
    check("b2b_restart", busy, 1'b1);
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 2 * FRAME_CYC) begin
      tick();
      n++;
    end
    check("b2b_done2", done, 1'b1);
    repeat (CPB * 3) tick();
    check("b2b_idle", busy, 1'b0);
    check("b2b_done_cnt", done_cnt - d0, 2);
    check("b2b_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
